// File: rtl/oc8051_tmr01_pkg.sv
// Shared definitions for the 8051 timer/counter 0/1 block.
// Contents: SFR addresses owned by the timers, the TMOD mode encoding,
// TMOD field bit positions, and an address-ownership helper.
package oc8051_tmr01_pkg;

  // SFR addresses
  localparam logic [7:0] ADDR_TMOD = 8'h89;
  localparam logic [7:0] ADDR_TL0  = 8'h8a;
  localparam logic [7:0] ADDR_TL1  = 8'h8b;
  localparam logic [7:0] ADDR_TH0  = 8'h8c;
  localparam logic [7:0] ADDR_TH1  = 8'h8d;

  // Timer mode encoding (TMOD M1:M0)
  typedef enum logic [1:0] {
    MODE_13B   = 2'b00,
    MODE_16B   = 2'b01,
    MODE_8AR   = 2'b10,
    MODE_SPLIT = 2'b11
  } tmr_mode_e;

  // TMOD field bit indices inside one nibble; timer 1 nibble sits at TMOD_T1_OFS
  localparam int TMOD_M0     = 0;
  localparam int TMOD_M1     = 1;
  localparam int TMOD_CT     = 2;
  localparam int TMOD_GATE   = 3;
  localparam int TMOD_T1_OFS = 4;

  function automatic logic is_owned(input logic [7:0] addr);
    return (addr == ADDR_TMOD) || (addr == ADDR_TL0) || (addr == ADDR_TL1) ||
           (addr == ADDR_TH0) || (addr == ADDR_TH1);
  endfunction

endpackage

// File: rtl/oc8051_tmr01_if.sv
// SFR bus between the core and the timer block.
// Handshake: there is no valid/ready pair; a write is accepted in the cycle
// where wr=1 and wr_bit=0, a read is continuous and data_out returns the
// register addressed by rd_addr one clock later.
//   wr_addr/rd_addr : SFR addresses
//   data_in         : write data
//   wr, wr_bit      : write strobe and bit-write qualifier
//   data_out        : registered read data
interface oc8051_tmr01_if;
  logic [7:0] wr_addr;
  logic [7:0] rd_addr;
  logic [7:0] data_in;
  logic       wr;
  logic       wr_bit;
  logic [7:0] data_out;

  modport master (output wr_addr, rd_addr, data_in, wr, wr_bit, input data_out);
  modport slave  (input wr_addr, rd_addr, data_in, wr, wr_bit, output data_out);
endinterface

// File: rtl/oc8051_tmr_cnt.sv
// One TH/TL timer pair with mode logic and write override.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   mode          : TMOD M1:M0 for this timer
//   en            : count enable (tick & run) for the main counter / TL
//   th_en         : independent TH increment, used only in MODE_SPLIT
//   wr_tl, wr_th  : byte writes; a write beats a count on the same register
//   data_in       : write data
//   tl, th        : register values
//   ovf           : combinational strobe, main counter (or TL in split) wraps
//   th_ovf        : combinational strobe, TH wraps in split mode
module oc8051_tmr_cnt
  import oc8051_tmr01_pkg::*;
#(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  tmr_mode_e  mode,
  input  logic       en,
  input  logic       th_en,
  input  logic       wr_tl,
  input  logic       wr_th,
  input  logic [7:0] data_in,
  output logic [7:0] tl,
  output logic [7:0] th,
  output logic       ovf,
  output logic       th_ovf
);

  logic [7:0]  tl_nxt;
  logic [7:0]  th_nxt;
  logic [12:0] cnt13;
  logic [15:0] cnt16;

  assign cnt13 = {th, tl[4:0]} + 13'd1;
  assign cnt16 = {th, tl} + 16'd1;

  always_comb begin
    tl_nxt = tl;
    th_nxt = th;
    ovf    = 1'b0;
    th_ovf = 1'b0;
    case (mode)
      MODE_13B: if (en) begin
        // TL[7:5] is not part of the 13-bit count and is held
        tl_nxt = {tl[7:5], cnt13[4:0]};
        // a TL write also blocks the carry into TH
        if (!wr_tl) th_nxt = cnt13[12:5];
        ovf = (cnt13 == 13'd0) && !wr_tl && !wr_th;
      end
      MODE_16B: if (en) begin
        tl_nxt = cnt16[7:0];
        if (!wr_tl) th_nxt = cnt16[15:8];
        ovf = (cnt16 == 16'd0) && !wr_tl && !wr_th;
      end
      MODE_8AR: if (en) begin
        tl_nxt = (tl == 8'hff) ? th : tl + 8'd1;
        ovf    = (tl == 8'hff) && !wr_tl;
      end
      MODE_SPLIT: begin
        if (en) begin
          tl_nxt = tl + 8'd1;
          ovf    = (tl == 8'hff) && !wr_tl;
        end
        if (th_en) begin
          th_nxt = th + 8'd1;
          th_ovf = (th == 8'hff) && !wr_th;
        end
      end
      default: ;
    endcase
    if (wr_tl) tl_nxt = data_in;
    if (wr_th) th_nxt = data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tl <= RST_VAL;
      th <= RST_VAL;
    end else begin
      tl <= tl_nxt;
      th <= th_nxt;
    end
  end

endmodule

// File: rtl/oc8051_tmr01.sv
// 8051 timer/counter 0 and 1: TMOD/TL0/TH0/TL1/TH1 SFRs, tick selection,
// gating, mode-3 split of timer 0 and overflow pulse routing.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   sfr              : SFR bus (slave side)
//   tr0, tr1         : run bits from TCON
//   t0, t1           : external counter pins
//   int0_n, int1_n   : gate pins
//   pres_ow          : machine-cycle tick
//   tf0, tf1         : registered one-cycle overflow pulses to the interrupt controller
//   t1_ow            : registered timer 1 overflow pulse for the UART
module oc8051_tmr01
  import oc8051_tmr01_pkg::*;
#(
  parameter logic [7:0] TMOD_RST = 8'h00,
  parameter logic [7:0] TMR_RST  = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  oc8051_tmr01_if.slave         sfr,
  input  logic                  tr0,
  input  logic                  tr1,
  input  logic                  t0,
  input  logic                  t1,
  input  logic                  int0_n,
  input  logic                  int1_n,
  input  logic                  pres_ow,
  output logic                  tf0,
  output logic                  tf1,
  output logic                  t1_ow
);

  logic [7:0] tmod;
  logic [7:0] tl0, th0, tl1, th1;
  logic       wr_en;
  // [0],[1]: synchronizer, [2]: previous synchronized value
  logic [2:0] t0_sync, t1_sync;
  logic       fall0, fall1;
  tmr_mode_e  mode0, mode1;
  logic       split0;
  logic       run0, run1, en0, en1, th0_en;
  logic       ovf0, ovf1, th0_ovf, ovf1_unused;

  assign wr_en = sfr.wr && !sfr.wr_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      t0_sync <= 3'b111;
      t1_sync <= 3'b111;
    end else begin
      t0_sync <= {t0_sync[1:0], t0};
      t1_sync <= {t1_sync[1:0], t1};
    end
  end

  assign fall0 = t0_sync[2] && !t0_sync[1];
  assign fall1 = t1_sync[2] && !t1_sync[1];

  assign mode0  = tmr_mode_e'(tmod[TMOD_M1:TMOD_M0]);
  assign mode1  = tmr_mode_e'(tmod[TMOD_T1_OFS+TMOD_M1:TMOD_T1_OFS+TMOD_M0]);
  assign split0 = (mode0 == MODE_SPLIT);

  assign run0 = tr0 && (!tmod[TMOD_GATE] || int0_n);
  // while timer 0 is split, TH0 borrows tr1 and timer 1 runs on its gate alone
  assign run1 = (split0 || tr1) && (!tmod[TMOD_T1_OFS+TMOD_GATE] || int1_n);
  assign en0  = run0 && (tmod[TMOD_CT] ? fall0 : pres_ow);
  // timer 1 in mode 3 is halted
  assign en1  = run1 && (tmod[TMOD_T1_OFS+TMOD_CT] ? fall1 : pres_ow) &&
                (mode1 != MODE_SPLIT);
  assign th0_en = split0 && pres_ow && tr1;

  oc8051_tmr_cnt #(.RST_VAL(TMR_RST)) u_cnt0 (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode0),
    .en     (en0),
    .th_en  (th0_en),
    .wr_tl  (wr_en && (sfr.wr_addr == ADDR_TL0)),
    .wr_th  (wr_en && (sfr.wr_addr == ADDR_TH0)),
    .data_in(sfr.data_in),
    .tl     (tl0),
    .th     (th0),
    .ovf    (ovf0),
    .th_ovf (th0_ovf)
  );

  oc8051_tmr_cnt #(.RST_VAL(TMR_RST)) u_cnt1 (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode1),
    .en     (en1),
    .th_en  (1'b0),
    .wr_tl  (wr_en && (sfr.wr_addr == ADDR_TL1)),
    .wr_th  (wr_en && (sfr.wr_addr == ADDR_TH1)),
    .data_in(sfr.data_in),
    .tl     (tl1),
    .th     (th1),
    .ovf    (ovf1),
    .th_ovf (ovf1_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tmod  <= TMOD_RST;
      tf0   <= 1'b0;
      tf1   <= 1'b0;
      t1_ow <= 1'b0;
    end else begin
      if (wr_en && (sfr.wr_addr == ADDR_TMOD)) tmod <= sfr.data_in;
      tf0   <= ovf0;
      // split mode hands tf1 to TH0; timer 1 then only feeds the UART
      tf1   <= split0 ? th0_ovf : ovf1;
      t1_ow <= ovf1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sfr.data_out <= 8'h00;
    end else if (wr_en && (sfr.wr_addr == sfr.rd_addr) && is_owned(sfr.rd_addr)) begin
      sfr.data_out <= sfr.data_in;
    end else begin
      case (sfr.rd_addr)
        ADDR_TMOD: sfr.data_out <= tmod;
        ADDR_TL0:  sfr.data_out <= tl0;
        ADDR_TL1:  sfr.data_out <= tl1;
        ADDR_TH0:  sfr.data_out <= th0;
        ADDR_TH1:  sfr.data_out <= th1;
        default:   sfr.data_out <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_oc8051_tmr01.sv
// Bench for oc8051_tmr01: directed scenarios plus a randomized phase, with a
// behavioural model predicting tf0/tf1/t1_ow/data_out every cycle.
module tb_oc8051_tmr01;
  import oc8051_tmr01_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tr0, tr1, t0, t1, int0_n, int1_n, pres_ow;
  logic tf0, tf1, t1_ow;

  always #5 clk = ~clk;

  oc8051_tmr01_if sfr ();

  oc8051_tmr01 #(.TMOD_RST(8'h00), .TMR_RST(8'h00)) dut (
    .clk    (clk),
    .rst    (rst),
    .sfr    (sfr),
    .tr0    (tr0),
    .tr1    (tr1),
    .t0     (t0),
    .t1     (t1),
    .int0_n (int0_n),
    .int1_n (int1_n),
    .pres_ow(pres_ow),
    .tf0    (tf0),
    .tf1    (tf1),
    .t1_ow  (t1_ow)
  );

  int checks   = 0;
  int failures = 0;
  int n_tf0 = 0, n_tf1 = 0, n_t1ow = 0;

  // ---------------- behavioural model ----------------
  // {tf0, tf1, t1_ow, data_out} expected after each clock edge
  logic [10:0] exp_q[$];
  logic [7:0]  m_tmod;
  int          m_tl[2];
  int          m_th[2];
  bit          pin_q0[$];
  bit          pin_q1[$];

  function automatic int reg_val(input logic [7:0] a);
    case (a)
      ADDR_TMOD: return int'(m_tmod);
      ADDR_TL0:  return m_tl[0];
      ADDR_TL1:  return m_tl[1];
      ADDR_TH0:  return m_th[0];
      ADDR_TH1:  return m_th[1];
      default:   return 0;
    endcase
  endfunction

  // one timer pair treated as a number in its mode's range
  task automatic advance(input int n, input bit en, input bit wtl, input bit wth,
                         input int d, output bit ovf);
    int tl, th, v, ntl, nth, mode;
    tl = m_tl[n]; th = m_th[n];
    ntl = tl; nth = th; ovf = 0;
    mode = (n == 0) ? int'(m_tmod[1:0]) : int'(m_tmod[5:4]);
    if (en) begin
      case (mode)
        0: begin
          v = (th * 32 + tl % 32 + 1) % 8192;
          ntl = (tl / 32) * 32 + v % 32; nth = v / 32; ovf = (v == 0);
          if (wtl) nth = th;
          if (wtl || wth) ovf = 0;
        end
        1: begin
          v = (th * 256 + tl + 1) % 65536;
          ntl = v % 256; nth = v / 256; ovf = (v == 0);
          if (wtl) nth = th;
          if (wtl || wth) ovf = 0;
        end
        2: begin
          ovf = (tl == 255);
          ntl = ovf ? th : tl + 1;
          if (wtl) ovf = 0;
        end
        default: begin
          ntl = (tl + 1) % 256; ovf = (ntl == 0);
          if (wtl) ovf = 0;
        end
      endcase
    end
    if (wtl) ntl = d;
    if (wth) nth = d;
    m_tl[n] = ntl; m_th[n] = nth;
  endtask

  task automatic model_step();
    bit w, f0, f1, split, en0, en1, ov0, ov1, ovh;
    logic [7:0] dout;
    int d;
    if (rst) begin
      m_tmod = 8'h00;
      m_tl = '{0, 0}; m_th = '{0, 0};
      pin_q0 = '{1'b1, 1'b1, 1'b1};
      pin_q1 = '{1'b1, 1'b1, 1'b1};
      exp_q.push_back(11'd0);
      return;
    end
    w = sfr.wr && !sfr.wr_bit;
    d = int'(sfr.data_in);
    if (w && sfr.wr_addr == sfr.rd_addr && is_owned(sfr.rd_addr)) dout = sfr.data_in;
    else dout = 8'(reg_val(sfr.rd_addr));
    // a falling edge counts three edges after the pin changes
    f0 = pin_q0[2] && !pin_q0[1];
    f1 = pin_q1[2] && !pin_q1[1];
    split = (m_tmod[1:0] == 2'b11);
    en0 = tr0 && (!m_tmod[3] || int0_n) && (m_tmod[2] ? f0 : pres_ow);
    en1 = (split || tr1) && (!m_tmod[7] || int1_n) && (m_tmod[6] ? f1 : pres_ow) &&
          (m_tmod[5:4] != 2'b11);
    advance(0, en0, w && sfr.wr_addr == ADDR_TL0, w && sfr.wr_addr == ADDR_TH0, d, ov0);
    advance(1, en1, w && sfr.wr_addr == ADDR_TL1, w && sfr.wr_addr == ADDR_TH1, d, ov1);
    ovh = 0;
    if (split && pres_ow && tr1 && !(w && sfr.wr_addr == ADDR_TH0)) begin
      m_th[0] = (m_th[0] + 1) % 256;
      ovh = (m_th[0] == 0);
    end
    if (w && sfr.wr_addr == ADDR_TMOD) m_tmod = sfr.data_in;
    exp_q.push_back({ov0, split ? ovh : ov1, ov1, dout});
    pin_q0.push_front(t0); void'(pin_q0.pop_back());
    pin_q1.push_front(t1); void'(pin_q1.pop_back());
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- scoreboard compare ----------------
  initial forever begin
    logic [10:0] e, got;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {tf0, tf1, t1_ow, sfr.data_out};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t got tf0=%b tf1=%b t1_ow=%b dout=%h exp tf0=%b tf1=%b t1_ow=%b dout=%h",
                 $time, got[10], got[9], got[8], got[7:0], e[10], e[9], e[8], e[7:0]);
      end
      if (tf0 === 1'b1) n_tf0++;
      if (tf1 === 1'b1) n_tf1++;
      if (t1_ow === 1'b1) n_t1ow++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic sfr_wr(input logic [7:0] a, input logic [7:0] d);
    sfr.wr = 1'b1; sfr.wr_addr = a; sfr.data_in = d;
    @(negedge clk);
    sfr.wr = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    sfr.rd_addr = a;
    @(negedge clk);
    chk(name, sfr.data_out, exp);
  endtask

  // machine-cycle ticks 12 clocks apart
  task automatic tick(input int n);
    repeat (n) begin
      pres_ow = 1'b1;
      @(negedge clk);
      pres_ow = 1'b0;
      idle(11);
    end
  endtask

  task automatic t0_edges(input int n);
    repeat (n) begin
      t0 = 1'b0; idle(3);
      t0 = 1'b1; idle(3);
    end
  endtask

  task automatic clr_cnt();
    n_tf0 = 0; n_tf1 = 0; n_t1ow = 0;
  endtask

  function automatic logic [7:0] rnd_addr();
    logic [7:0] tbl[5];
    int k;
    tbl = '{ADDR_TMOD, ADDR_TL0, ADDR_TL1, ADDR_TH0, ADDR_TH1};
    k = $urandom_range(0, 5);
    return (k == 5) ? 8'($urandom_range(0, 255)) : tbl[k];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    sfr.wr = 0; sfr.wr_bit = 0; sfr.wr_addr = 0; sfr.rd_addr = 0; sfr.data_in = 0;
    tr0 = 0; tr1 = 0; t0 = 1; t1 = 1; int0_n = 1; int1_n = 1; pres_ow = 0;
    idle(3);
    rst = 1'b0;
    read_chk("reset_tmod", ADDR_TMOD, 8'h00);
    read_chk("reset_th1", ADDR_TH1, 8'h00);

    // mode 1 wrap of timer 0
    sfr_wr(ADDR_TMOD, 8'h01); sfr_wr(ADDR_TL0, 8'hfe); sfr_wr(ADDR_TH0, 8'hff);
    clr_cnt(); tr0 = 1;
    tick(1);
    read_chk("m1_tl0_ff", ADDR_TL0, 8'hff);
    tick(1);
    read_chk("m1_tl0_00", ADDR_TL0, 8'h00);
    read_chk("m1_th0_00", ADDR_TH0, 8'h00);
    chk("m1_tf0_cnt", 8'(n_tf0), 8'd1);
    chk("m1_tf1_cnt", 8'(n_tf1), 8'd0);
    tr0 = 0;

    // mode 2 auto-reload of timer 1
    sfr_wr(ADDR_TMOD, 8'h20); sfr_wr(ADDR_TH1, 8'hf0); sfr_wr(ADDR_TL1, 8'hfe);
    clr_cnt(); tr1 = 1;
    tick(1);
    read_chk("m2_tl1_ff", ADDR_TL1, 8'hff);
    tick(1);
    read_chk("m2_tl1_reload", ADDR_TL1, 8'hf0);
    read_chk("m2_th1_hold", ADDR_TH1, 8'hf0);
    chk("m2_tf1_cnt", 8'(n_tf1), 8'd1);
    chk("m2_t1ow_cnt", 8'(n_t1ow), 8'd1);
    tick(15);
    chk("m2_tf1_cnt_15", 8'(n_tf1), 8'd1);
    tick(1);
    chk("m2_tf1_cnt_16", 8'(n_tf1), 8'd2);
    tr1 = 0;

    // gated external counter
    sfr_wr(ADDR_TMOD, 8'h0d); sfr_wr(ADDR_TL0, 8'h00); sfr_wr(ADDR_TH0, 8'h00);
    tr0 = 1; int0_n = 0;
    sfr.rd_addr = ADDR_TL0;
    t0_edges(5);
    read_chk("gate_blocked", ADDR_TL0, 8'h00);
    int0_n = 1;
    t0_edges(5);
    read_chk("gate_open", ADDR_TL0, 8'h05);
    t0 = 1'b0; idle(3);
    chk("edge_lat_3", sfr.data_out, 8'h05);
    idle(1);
    chk("edge_lat_4", sfr.data_out, 8'h06);
    t0 = 1'b1; idle(3);
    tr0 = 0;

    // timer 0 split mode
    sfr_wr(ADDR_TMOD, 8'h03); sfr_wr(ADDR_TL1, 8'h00); sfr_wr(ADDR_TH1, 8'h00);
    sfr_wr(ADDR_TL0, 8'hff); sfr_wr(ADDR_TH0, 8'hff);
    clr_cnt(); tr0 = 1; tr1 = 1;
    tick(1);
    chk("split_tf0", 8'(n_tf0), 8'd1);
    chk("split_tf1", 8'(n_tf1), 8'd1);
    chk("split_t1ow0", 8'(n_t1ow), 8'd0);
    sfr_wr(ADDR_TMOD, 8'h23); sfr_wr(ADDR_TL1, 8'hff); sfr_wr(ADDR_TH1, 8'h00);
    tick(1);
    chk("split_t1ow1", 8'(n_t1ow), 8'd1);
    chk("split_tf1_hold", 8'(n_tf1), 8'd1);
    read_chk("split_th0", ADDR_TH0, 8'h01);
    tr0 = 0; tr1 = 0;

    // write beats count
    sfr_wr(ADDR_TMOD, 8'h01); sfr_wr(ADDR_TL0, 8'hff); sfr_wr(ADDR_TH0, 8'hff);
    clr_cnt(); tr0 = 1;
    sfr.wr = 1; sfr.wr_addr = ADDR_TL0; sfr.data_in = 8'h55; pres_ow = 1;
    @(negedge clk);
    sfr.wr = 0; pres_ow = 0;
    idle(11);
    read_chk("wr_win_tl0", ADDR_TL0, 8'h55);
    read_chk("wr_win_th0", ADDR_TH0, 8'hff);
    chk("wr_win_tf0", 8'(n_tf0), 8'd0);
    tr0 = 0;

    // write-through read
    sfr.wr = 1; sfr.wr_addr = ADDR_TH1; sfr.data_in = 8'ha5; sfr.rd_addr = ADDR_TH1;
    @(negedge clk);
    sfr.wr = 0;
    chk("wr_through", sfr.data_out, 8'ha5);

    // reset while counting, right as an overflow pulse is out
    sfr_wr(ADDR_TL0, 8'hff); sfr_wr(ADDR_TH0, 8'hff);
    tr0 = 1; pres_ow = 1;
    @(negedge clk);
    pres_ow = 0; rst = 1;
    @(negedge clk);
    chk("rst_tf0", {7'd0, tf0}, 8'd0);
    chk("rst_tf1", {7'd0, tf1}, 8'd0);
    rst = 0; tr0 = 0;
    read_chk("rst_tl0", ADDR_TL0, 8'h00);
    read_chk("rst_th1", ADDR_TH1, 8'h00);
    read_chk("rst_tmod", ADDR_TMOD, 8'h00);

    // randomized phase
    for (int i = 0; i < 5000; i++) begin
      rst = ($urandom_range(0, 699) == 0);
      pres_ow = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) t0 = ~t0;
      if ($urandom_range(0, 3) == 0) t1 = ~t1;
      if ($urandom_range(0, 15) == 0) tr0 = ~tr0;
      if ($urandom_range(0, 15) == 0) tr1 = ~tr1;
      if ($urandom_range(0, 7) == 0) int0_n = ~int0_n;
      if ($urandom_range(0, 7) == 0) int1_n = ~int1_n;
      sfr.wr = ($urandom_range(0, 3) == 0);
      sfr.wr_bit = ($urandom_range(0, 3) == 0);
      sfr.wr_addr = rnd_addr();
      sfr.rd_addr = ($urandom_range(0, 3) == 0) ? sfr.wr_addr : rnd_addr();
      // bias the data toward wrap boundaries
      sfr.data_in = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(250, 255))
                                                : 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    rst = 0; sfr.wr = 0; pres_ow = 0;
    idle(2);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
